eq_band_gain_ctrl: RTL and testbench

//   Configuration sequencer for the 8-band equalizer datapath (Filter ->

---
 rtl/eq_ctrl_pkg.sv | 31 +++
 rtl/eq_band_ramp.sv | 102 ++++++++++
 rtl/eq_band_gain_ctrl.sv | 91 +++++++++
 tb/tb_eq_band_gain_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_ctrl_pkg.sv
// Shared definitions for the 8-band equalizer control path.
// The amplifier and the testbench reuse the band count, the gain code width
// and the per-band state encoding from here.
package eq_ctrl_pkg;

    localparam int NUM_BANDS = 8;
    localparam int COEF_W    = 3;
    localparam int BAND_W    = 3;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        RAMP   = 2'd1,
        STEADY = 2'd2,
        FADE   = 2'd3
    } band_state_t;

    // Moves a gain code one step toward its goal. Because it never overshoots,
    // the result cannot leave 0..2**COEF_W-1.
    function automatic logic [COEF_W-1:0] stepToward(
        input logic [COEF_W-1:0] cur,
        input logic [COEF_W-1:0] goal
    );
        if (cur < goal) begin
            return cur + COEF_W'(1);
        end else if (cur > goal) begin
            return cur - COEF_W'(1);
        end
        return cur;
    endfunction

endpackage

// File: rtl/eq_band_ramp.sv
// One equalizer band: stores the host target gain and walks the output gain
// code one step per ramp tick. The filter enable only drops once the gain has
// faded all the way to zero.
module eq_band_ramp
    import eq_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              tick_i,
    input  logic              wr_i,
    input  logic [COEF_W-1:0] wr_coef_i,
    input  logic              wr_ena_i,
    input  logic              mute_i,
    output logic              ena_o,
    output logic [COEF_W-1:0] cur_o,
    output logic              active_o
);

    band_state_t       state_q, state_d;
    logic [COEF_W-1:0] target_q, target_d;
    logic [COEF_W-1:0] cur_q, cur_d;
    logic              ena_q, ena_d;
    logic [COEF_W-1:0] effTarget;
    logic [COEF_W-1:0] wrEffCoef;

    // Mute pulls the goal to zero without losing the stored target.
    assign effTarget = mute_i ? '0 : target_q;
    assign wrEffCoef = mute_i ? '0 : wr_coef_i;

    // Next-state logic: band FSM, target capture, gain stepping and enable.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cur_d    = cur_q;
        ena_d    = ena_q;

        if (wr_i && wr_ena_i) begin
            target_d = wr_coef_i;
        end

        if (wr_i && wr_ena_i) begin
            ena_d = 1'b1;
        end else if (state_q == OFF) begin
            ena_d = 1'b0;
        end

        case (state_q)
            OFF: begin
                if (wr_i && wr_ena_i) begin
                    state_d = RAMP;
                end
            end
            RAMP, STEADY: begin
                if (wr_i && !wr_ena_i) begin
                    state_d = (cur_q == '0) ? OFF : FADE;
                end else if (wr_i && wr_ena_i) begin
                    state_d = (wrEffCoef != cur_q) ? RAMP : state_q;
                end else if (tick_i) begin
                    cur_d   = stepToward(cur_q, effTarget);
                    state_d = (cur_d == effTarget) ? STEADY : RAMP;
                end else if (cur_q != effTarget) begin
                    state_d = RAMP;
                end
            end
            FADE: begin
                if (wr_i && wr_ena_i) begin
                    state_d = RAMP;
                end else if (tick_i) begin
                    if (cur_q <= COEF_W'(1)) begin
                        cur_d   = '0;
                        state_d = OFF;
                    end else begin
                        cur_d = cur_q - COEF_W'(1);
                    end
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase
    end

    // Band registers; reset drops the band straight to off with no fade.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= OFF;
            target_q <= '0;
            cur_q    <= '0;
            ena_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cur_q    <= cur_d;
            ena_q    <= ena_d;
        end
    end

    assign ena_o    = ena_q;
    assign cur_o    = cur_q;
    assign active_o = (state_q == RAMP) || (state_q == FADE);

endmodule

// File: rtl/eq_band_gain_ctrl.sv
// Configuration sequencer for the 8-band equalizer: divides sample strobes
// into ramp ticks, routes host writes to the addressed band and gathers the
// per-band enables and gain codes onto the filter/amplifier buses.
module eq_band_gain_ctrl
    import eq_ctrl_pkg::*;
#(
    parameter int RAMP_DIV = 4,
    parameter int DIV_W    = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          sample_en_i,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic [BAND_W-1:0]             cfg_band_i,
    input  logic [COEF_W-1:0]             cfg_coef_i,
    input  logic                          cfg_ena_i,
    input  logic                          mute_i,
    output logic [NUM_BANDS-1:0]          ena_bus_o,
    output logic [NUM_BANDS*COEF_W-1:0]   amp_coef_bus_o,
    output logic                          busy_o,
    output logic                          ramp_done_o
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

    logic [DIV_W-1:0]  divCnt_q, divCnt_d;
    logic              busy_q, busy_d;
    logic              rampDone_q, rampDone_d;
    logic              tick;
    logic              accept;
    logic              anyActive;
    logic [NUM_BANDS-1:0] bandWr;
    logic [NUM_BANDS-1:0] bandEna;
    logic [NUM_BANDS-1:0] bandActive;
    logic [COEF_W-1:0]    bandCur [NUM_BANDS];

    // A tick is the strobe that completes a group of RAMP_DIV samples; writes
    // are refused on that cycle so a band never sees a write and a step at once.
    assign tick        = sample_en_i && (divCnt_q == DIV_LAST);
    assign cfg_ready_o = ~tick;
    assign accept      = cfg_valid_i && ~tick;
    assign anyActive   = |bandActive;

    // Next divider count plus the busy/done edge detector.
    always_comb begin
        divCnt_d   = divCnt_q;
        busy_d     = anyActive;
        rampDone_d = busy_q && !anyActive;
        if (sample_en_i) begin
            divCnt_d = tick ? '0 : divCnt_q + DIV_W'(1);
        end
    end

    // Divider and status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            divCnt_q   <= '0;
            busy_q     <= 1'b0;
            rampDone_q <= 1'b0;
        end else begin
            divCnt_q   <= divCnt_d;
            busy_q     <= busy_d;
            rampDone_q <= rampDone_d;
        end
    end

    for (genvar b = 0; b < NUM_BANDS; b++) begin : gBand
        assign bandWr[b] = accept && (cfg_band_i == BAND_W'(b));

        eq_band_ramp uBand (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .tick_i    (tick),
            .wr_i      (bandWr[b]),
            .wr_coef_i (cfg_coef_i),
            .wr_ena_i  (cfg_ena_i),
            .mute_i    (mute_i),
            .ena_o     (bandEna[b]),
            .cur_o     (bandCur[b]),
            .active_o  (bandActive[b])
        );

        assign amp_coef_bus_o[b*COEF_W +: COEF_W] = bandCur[b];
    end

    assign ena_bus_o   = bandEna;
    assign busy_o      = busy_q;
    assign ramp_done_o = rampDone_q;

endmodule

// File: tb/tb_eq_band_gain_ctrl.sv
// Self-checking bench for eq_band_gain_ctrl: directed scenarios plus a random
// phase, all compared every cycle against a behavioural band model.
module tb_eq_band_gain_ctrl;
    import eq_ctrl_pkg::*;

    localparam int RAMP_DIV = 4;

    logic        clk = 1'b0;
    logic        rstN;
    logic        sampleEn;
    logic        cfgValid;
    logic        cfgReady;
    logic [2:0]  cfgBand;
    logic [2:0]  cfgCoef;
    logic        cfgEna;
    logic        mute;
    logic [7:0]  enaBus;
    logic [23:0] ampBus;
    logic        busy;
    logic        rampDone;

    eq_band_gain_ctrl #(.RAMP_DIV(RAMP_DIV), .DIV_W(8)) dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .sample_en_i    (sampleEn),
        .cfg_valid_i    (cfgValid),
        .cfg_ready_o    (cfgReady),
        .cfg_band_i     (cfgBand),
        .cfg_coef_i     (cfgCoef),
        .cfg_ena_i      (cfgEna),
        .mute_i         (mute),
        .ena_bus_o      (enaBus),
        .amp_coef_bus_o (ampBus),
        .busy_o         (busy),
        .ramp_done_o    (rampDone)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: gain codes, stored targets, on/fading flags, enables.
    int mDiv;
    int mCur [8];
    int mTgt [8];
    bit mOn  [8];
    bit mFade[8];
    bit mEna [8];
    int tickTotal     = 0;
    int rampDonePulses = 0;
    int cycNo         = 0;
    int sampleMode    = 1;
    bit sampleForce   = 1'b0;
    bit lastReady;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic void modelReset();
        mDiv = 0;
        for (int b = 0; b < 8; b++) begin
            mCur[b] = 0; mTgt[b] = 0; mOn[b] = 0; mFade[b] = 0; mEna[b] = 0;
        end
    endfunction

    function automatic int codeOf(input int band);
        return int'(ampBus[band*3 +: 3]);
    endfunction

    // Advance the model across one clock edge with the current inputs.
    function automatic void modelEdge(input bit tk, input bit acc);
        for (int b = 0; b < 8; b++) begin
            bit wrB;
            bit newEna;
            int goal;
            wrB    = acc && (int'(cfgBand) == b);
            newEna = mEna[b];
            if (wrB && cfgEna) newEna = 1'b1;
            else if (!mOn[b])  newEna = 1'b0;
            if (tk && mOn[b]) begin
                if (mFade[b]) begin
                    mCur[b]--;
                    if (mCur[b] == 0) begin mOn[b] = 0; mFade[b] = 0; end
                end else begin
                    goal = mute ? 0 : mTgt[b];
                    if (mCur[b] < goal) mCur[b]++;
                    else if (mCur[b] > goal) mCur[b]--;
                end
            end
            if (wrB) begin
                if (cfgEna) begin
                    mTgt[b] = int'(cfgCoef); mOn[b] = 1; mFade[b] = 0;
                end else if (mOn[b] && !mFade[b]) begin
                    if (mCur[b] == 0) mOn[b] = 0;
                    else mFade[b] = 1;
                end
            end
            mEna[b] = newEna;
        end
        if (sampleEn) mDiv = tk ? 0 : mDiv + 1;
        if (tk) tickTotal++;
    endfunction

    // Drives the sample strobe, checks ready, then checks the buses after the edge.
    task automatic applyStimulus(output bit accepted, output bit tk);
        logic [7:0]  expEna;
        logic [23:0] expBus;
        cycNo++;
        case (sampleMode)
            0:       sampleEn = 1'($urandom_range(0, 1));
            1:       sampleEn = (cycNo % 2 == 0);
            default: sampleEn = sampleForce;
        endcase
        #1;
        tk        = sampleEn && (mDiv == RAMP_DIV - 1);
        accepted  = cfgValid && !tk;
        lastReady = cfgReady;
        checkOutput("cfg_ready", 32'(cfgReady), 32'(!tk));
        modelEdge(tk, accepted);
        @(posedge clk);
        #1;
        for (int b = 0; b < 8; b++) begin
            expEna[b]       = mEna[b];
            expBus[b*3 +: 3] = 3'(mCur[b]);
        end
        checkOutput("ena_bus", 32'(enaBus), 32'(expEna));
        checkOutput("amp_coef_bus", 32'(ampBus), 32'(expBus));
        if (rampDone) rampDonePulses++;
    endtask

    task automatic runCycles(input int n);
        bit acc, tk;
        for (int i = 0; i < n; i++) applyStimulus(acc, tk);
    endtask

    task automatic writeCfg(input int band, input int coef, input bit ena);
        bit acc, tk;
        int n = 0;
        cfgValid = 1'b1;
        cfgBand  = 3'(band);
        cfgCoef  = 3'(coef);
        cfgEna   = ena;
        do begin
            applyStimulus(acc, tk);
            n++;
        end while (!acc && n < 20);
        cfgValid = 1'b0;
        checkOutput("write_accept", 32'(acc), 32'(1));
    endtask

    task automatic waitQuiet(input string tag, input int maxCyc);
        int n = 2;
        runCycles(2);
        while (busy && n < maxCyc) begin
            runCycles(1);
            n++;
        end
        checkOutput(tag, 32'(busy), 32'(0));
    endtask

    task automatic waitCode(input string tag, input int band, input int value, input int maxCyc);
        int n = 0;
        while (codeOf(band) != value && n < maxCyc) begin
            runCycles(1);
            n++;
        end
        checkOutput(tag, 32'(codeOf(band)), 32'(value));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc, tk;
        int mark;
        int seq[$];
        int prev;
        rstN = 1'b0; sampleEn = 0; cfgValid = 0; cfgBand = 0; cfgCoef = 0; cfgEna = 0; mute = 0;
        modelReset();

        // Reset held with random inputs: every output stays at zero.
        for (int i = 0; i < 5; i++) begin
            sampleEn = 1'($urandom_range(0, 1));
            cfgValid = 1'($urandom_range(0, 1));
            cfgBand  = 3'($urandom_range(0, 7));
            cfgCoef  = 3'($urandom_range(0, 7));
            cfgEna   = 1'($urandom_range(0, 1));
            mute     = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checkOutput("rst_ena_bus", 32'(enaBus), 32'(0));
            checkOutput("rst_amp_bus", 32'(ampBus), 32'(0));
            checkOutput("rst_busy", 32'({busy, rampDone}), 32'(0));
        end
        sampleEn = 0; cfgValid = 0; mute = 0;
        #1;
        checkOutput("rst_ready_idle", 32'(cfgReady), 32'(1));
        #1;
        rstN = 1'b1;
        modelReset();

        // Enable band 3 at gain 5: five ticks up, then one ramp_done pulse.
        sampleMode = 1;
        rampDonePulses = 0;
        mark = tickTotal;
        writeCfg(3, 5, 1);
        checkOutput("t2_ena_next_cycle", 32'(enaBus[3]), 32'(1));
        waitQuiet("t2_busy_falls", 200);
        checkOutput("t2_code", 32'(codeOf(3)), 32'(5));
        checkOutput("t2_ticks", 32'(tickTotal - mark), 32'(5));
        runCycles(4);
        checkOutput("t2_ramp_done_pulses", 32'(rampDonePulses), 32'(1));

        // Disable band 3: fades 4..0 and the enable drops afterwards.
        mark = tickTotal;
        writeCfg(3, 0, 0);
        waitQuiet("t3_busy_falls", 200);
        runCycles(2);
        checkOutput("t3_code", 32'(codeOf(3)), 32'(0));
        checkOutput("t3_ena_off", 32'(enaBus[3]), 32'(0));
        checkOutput("t3_ticks", 32'(tickTotal - mark), 32'(5));

        // Write collides with the tick that lifts band 0 to 4, then retargets to 2.
        writeCfg(0, 6, 1);
        waitCode("t4_reach_3", 0, 3, 200);
        sampleMode = 2;
        sampleForce = 1'b1;
        for (int i = 0; i < 8 && mDiv != RAMP_DIV - 1; i++) runCycles(1);
        cfgValid = 1'b1; cfgBand = 3'd0; cfgCoef = 3'd2; cfgEna = 1'b1;
        applyStimulus(acc, tk);
        checkOutput("t4_ready_in_tick", 32'(lastReady), 32'(0));
        checkOutput("t4_not_taken_in_tick", 32'(acc), 32'(0));
        checkOutput("t4_code_at_collision", 32'(codeOf(0)), 32'(4));
        sampleForce = 1'b0;
        applyStimulus(acc, tk);
        checkOutput("t4_taken_next_cycle", 32'(acc), 32'(1));
        cfgValid = 1'b0;
        sampleMode = 1;
        prev = codeOf(0);
        for (int i = 0; i < 200 && codeOf(0) != 2; i++) begin
            runCycles(1);
            if (codeOf(0) != prev) begin
                prev = codeOf(0);
                seq.push_back(prev);
            end
        end
        checkOutput("t4_steps", 32'(seq.size()), 32'(2));
        if (seq.size() == 2) begin
            checkOutput("t4_first_step", 32'(seq[0]), 32'(3));
            checkOutput("t4_second_step", 32'(seq[1]), 32'(2));
        end
        waitQuiet("t4_busy_falls", 200);

        // Mute fades bands 1 and 6 with enables held; release restores them.
        writeCfg(1, 7, 1);
        writeCfg(6, 3, 1);
        waitQuiet("t5_on_quiet", 300);
        checkOutput("t5_band1_on", 32'(codeOf(1)), 32'(7));
        mute = 1'b1;
        mark = tickTotal;
        waitQuiet("t5_mute_quiet", 300);
        checkOutput("t5_muted_codes", 32'({codeOf(1), codeOf(6)}), 32'(0));
        checkOutput("t5_muted_enas", 32'({enaBus[1], enaBus[6]}), 32'(2'b11));
        checkOutput("t5_mute_ticks", 32'(tickTotal - mark), 32'(7));
        mute = 1'b0;
        mark = tickTotal;
        waitQuiet("t5_unmute_quiet", 300);
        checkOutput("t5_band1_restored", 32'(codeOf(1)), 32'(7));
        checkOutput("t5_band6_restored", 32'(codeOf(6)), 32'(3));
        checkOutput("t5_unmute_ticks", 32'(tickTotal - mark), 32'(7));

        // Reset pulse while band 2 ramps at 3: outputs clear at once.
        writeCfg(2, 6, 1);
        waitCode("t6_reach_3", 2, 3, 200);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("t6_rst_amp_bus", 32'(ampBus), 32'(0));
        checkOutput("t6_rst_ena_bus", 32'(enaBus), 32'(0));
        checkOutput("t6_rst_status", 32'({busy, rampDone}), 32'(0));
        @(posedge clk);
        #2;
        rstN = 1'b1;
        modelReset();
        writeCfg(2, 2, 1);
        waitCode("t6_first_step", 2, 1, 200);
        waitQuiet("t6_busy_falls", 200);
        checkOutput("t6_final", 32'(codeOf(2)), 32'(2));

        // Random phase: host writes held until accepted, mute toggling, random strobes.
        sampleMode = 0;
        for (int i = 0; i < 500; i++) begin
            if (!cfgValid && $urandom_range(0, 3) == 0) begin
                cfgValid = 1'b1;
                cfgBand  = 3'($urandom_range(0, 7));
                cfgCoef  = 3'($urandom_range(0, 7));
                cfgEna   = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 39) == 0) mute = ~mute;
            applyStimulus(acc, tk);
            if (acc) cfgValid = 1'b0;
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
